latch_id_ex_hazard: RTL and testbench
=====================================

// Module: latch_id_ex_hazard
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Captures decoded operands,
//  register specifiers and control from the ID stage and presents them to EX. Its rs/rt/reg_write
//  outputs feed unit_forward directly. Inserts bubbles on load-use and on flush, and counts them.
// PARAMETERS
//  NB_REG   5   register specifier width
//  NB_DATA  32  operand / immediate width
//  NB_CTRL  10  control bundle width: [0]reg_write [1]mem_read [2]mem_write [3]mem_to_reg
//               [4]alu_src [5]reg_dst [9:6]alu_op
//  NB_CNT   16  bubble counter width
// PORTS
//  i_clk            in   1        clock, rising edge
//  i_rst_n          in   1        asynchronous reset, active low
//  i_enable         in   1        debug step enable; 0 freezes all state
//  i_flush          in   1        branch/jump taken: squash the instruction entering EX
//  i_cnt_clear      in   1        synchronous clear of o_bubble_cnt
//  i_IF_ID_rs       in   NB_REG   rs of the instruction in ID
//  i_IF_ID_rt       in   NB_REG   rt of the instruction in ID
//  i_IF_ID_rd       in   NB_REG   rd of the instruction in ID
//  i_uses_rt        in   1        ID instruction reads rt as a source
//  i_ctrl           in   NB_CTRL  decoded control bundle
//  i_data_a         in   NB_DATA  register file read A
//  i_data_b         in   NB_DATA  register file read B
//  i_imm            in   NB_DATA  sign-extended immediate
//  o_stall          out  1        combinational load-use stall: hold PC and IF/ID
//  o_ID_EX_rs       out  NB_REG   registered rs (to unit_forward)
//  o_ID_EX_rt       out  NB_REG   registered rt (to unit_forward)
//  o_ID_EX_rd       out  NB_REG   registered rd
//  o_ctrl           out  NB_CTRL  registered control bundle
//  o_data_a         out  NB_DATA  registered operand A
//  o_data_b         out  NB_DATA  registered operand B
//  o_imm            out  NB_DATA  registered immediate
//  o_valid          out  1        1 = EX holds a real instruction, 0 = bubble
//  o_bubble_cnt     out  NB_CNT   saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): every registered output = 0, o_valid=0, o_bubble_cnt=0; o_stall
//    reads 0 because it is derived from the registered mem_read, which is 0.
//  - Hazard (combinational): o_stall = o_ctrl[1] & o_valid & (o_ID_EX_rt!=0) &
//    ((o_ID_EX_rt==i_IF_ID_rs) | (i_uses_rt & (o_ID_EX_rt==i_IF_ID_rt))). o_stall is not gated
//    by i_enable.
//  - Per rising edge with i_enable=1, priority order:
//      1. i_flush=1  -> bubble: o_ctrl=0, o_valid=0, rs/rt/rd=0, data/imm=0; cnt+1.
//      2. o_stall=1  -> bubble as in 1; cnt+1. One bubble per stall, because the next cycle's
//                       o_ctrl[1]=0 drops o_stall.
//      3. otherwise  -> load all i_* fields; o_valid=1.
//  - i_enable=0: all registers hold, including the counter. i_cnt_clear is also ignored.
//  - Counter: saturates at 2^NB_CNT-1 and does not wrap. i_cnt_clear (with enable) forces 0 and
//    overrides an increment in the same cycle.
//  - Flush and stall in the same cycle: exactly one bubble is inserted and cnt increments by 1.
//  - Latency: 1 cycle from ID inputs to EX outputs. o_stall has 0 cycles of latency.
//  - No other state machine exists. Per cycle the state is VALID or BUBBLE, held in o_valid.
// TESTING
//  1. Reset mid-stream: drive valid ID data, assert i_rst_n=0 between edges -> all outputs 0
//     immediately, without waiting for a clock.
//  2. Pass-through: ctrl=10'h021, rs=1, rt=2, rd=3, data_a=32'hA, no hazard -> one edge later
//     outputs match, o_valid=1, o_stall=0.
//  3. Load-use: lw in EX with rt=5 (ctrl[1]=1); ID has rs=5 -> o_stall=1. Next edge: o_ctrl=0,
//     o_valid=0, cnt=1, o_stall=0. Following edge: the ID instruction loads.
//  4. No false stall: lw rt=0 with ID rs=0 -> o_stall=0. lw rt=7 with ID rt=7 and i_uses_rt=0
//     -> o_stall=0.
//  5. Flush + stall in the same cycle -> one bubble, cnt +1 only. Then i_enable=0 for 3 cycles
//     -> outputs and cnt frozen.
//  6. Saturation: NB_CNT=2, insert 5 bubbles -> cnt=3. Then i_cnt_clear together with a flush
//     -> cnt=0.

Source files
------------

// File: rtl/latch_id_ex_hazard.sv
// latch_id_ex_hazard
//   ID/EX pipeline register with built-in load-use hazard detection.
//   Captures the operands, register specifiers and control of the
//   instruction in ID and presents them to EX one cycle later. A bubble is
//   inserted on a flush or a load-use stall. Inserted bubbles are counted
//   by a saturating counter.
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_enable            debug step enable; 0 holds every register
//   i_flush             squash the instruction entering EX
//   i_cnt_clear         synchronous clear of o_bubble_cnt (needs i_enable)
//   i_IF_ID_rs/rt/rd    register specifiers of the instruction in ID
//   i_uses_rt           the instruction in ID reads rt as a source
//   i_ctrl              control bundle: [0]reg_write [1]mem_read
//                       [2]mem_write [3]mem_to_reg [4]alu_src [5]reg_dst
//                       [9:6]alu_op
//   i_data_a/b, i_imm   register file reads and sign-extended immediate
//   o_stall             combinational load-use stall (hold PC and IF/ID)
//   o_ID_EX_*, o_ctrl,
//   o_data_a/b, o_imm   registered EX-side copies
//   o_valid             1 = EX holds a real instruction, 0 = bubble
//   o_bubble_cnt        saturating count of inserted bubbles
module latch_id_ex_hazard #(
    parameter int NB_REG  = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 10,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_cnt_clear,
    input  logic [NB_REG-1:0]  i_IF_ID_rs,
    input  logic [NB_REG-1:0]  i_IF_ID_rt,
    input  logic [NB_REG-1:0]  i_IF_ID_rd,
    input  logic               i_uses_rt,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_DATA-1:0] i_imm,
    output logic               o_stall,
    output logic [NB_REG-1:0]  o_ID_EX_rs,
    output logic [NB_REG-1:0]  o_ID_EX_rt,
    output logic [NB_REG-1:0]  o_ID_EX_rd,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_DATA-1:0] o_imm,
    output logic               o_valid,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    logic [NB_REG-1:0]  rs_q, rt_q, rd_q;
    logic [NB_CTRL-1:0] ctrl_q;
    logic [NB_DATA-1:0] data_a_q, data_b_q, imm_q;
    logic               valid_q;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               bubble;

    // A load in EX whose destination (rt) is a source of the instruction in
    // ID. Register 0 is hardwired zero and never creates a dependency.
    // Because the stalled cycle turns EX into a bubble, mem_read drops on
    // the next cycle and the stall lasts exactly one cycle.
    assign o_stall = ctrl_q[1] & valid_q & (rt_q != '0) &
                     ((rt_q == i_IF_ID_rs) | (i_uses_rt & (rt_q == i_IF_ID_rt)));

    // Flush and stall together still produce a single bubble.
    assign bubble = i_flush | o_stall;

    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clear)
            cnt_d = '0;
        else if (bubble && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (i_enable) begin
            cnt_q <= cnt_d;
            if (bubble) begin
                rs_q     <= '0;
                rt_q     <= '0;
                rd_q     <= '0;
                ctrl_q   <= '0;
                data_a_q <= '0;
                data_b_q <= '0;
                imm_q    <= '0;
                valid_q  <= 1'b0;
            end else begin
                rs_q     <= i_IF_ID_rs;
                rt_q     <= i_IF_ID_rt;
                rd_q     <= i_IF_ID_rd;
                ctrl_q   <= i_ctrl;
                data_a_q <= i_data_a;
                data_b_q <= i_data_b;
                imm_q    <= i_imm;
                valid_q  <= 1'b1;
            end
        end
    end

    assign o_ID_EX_rs   = rs_q;
    assign o_ID_EX_rt   = rt_q;
    assign o_ID_EX_rd   = rd_q;
    assign o_ctrl       = ctrl_q;
    assign o_data_a     = data_a_q;
    assign o_data_b     = data_b_q;
    assign o_imm        = imm_q;
    assign o_valid      = valid_q;
    assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_latch_id_ex_hazard.sv
// Directed bench for latch_id_ex_hazard. Two instances share all inputs:
// u_dut uses the default 16-bit counter and u_sat uses a 2-bit counter to
// exercise saturation.
module tb_latch_id_ex_hazard;

    logic        clk = 1'b0;
    logic        rst_n, enable, flush, cnt_clear, uses_rt;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    logic [31:0] da, db, imm;

    logic        stall, valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] cnt;

    logic        s_stall, s_valid;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [9:0]  s_ctrl;
    logic [31:0] s_a, s_b, s_imm;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_id_ex_hazard u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush),
        .i_cnt_clear(cnt_clear), .i_IF_ID_rs(rs), .i_IF_ID_rt(rt),
        .i_IF_ID_rd(rd), .i_uses_rt(uses_rt), .i_ctrl(ctrl),
        .i_data_a(da), .i_data_b(db), .i_imm(imm),
        .o_stall(stall), .o_ID_EX_rs(ex_rs), .o_ID_EX_rt(ex_rt),
        .o_ID_EX_rd(ex_rd), .o_ctrl(ex_ctrl), .o_data_a(ex_a),
        .o_data_b(ex_b), .o_imm(ex_imm), .o_valid(valid), .o_bubble_cnt(cnt)
    );

    latch_id_ex_hazard #(.NB_CNT(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush),
        .i_cnt_clear(cnt_clear), .i_IF_ID_rs(rs), .i_IF_ID_rt(rt),
        .i_IF_ID_rd(rd), .i_uses_rt(uses_rt), .i_ctrl(ctrl),
        .i_data_a(da), .i_data_b(db), .i_imm(imm),
        .o_stall(s_stall), .o_ID_EX_rs(s_rs), .o_ID_EX_rt(s_rt),
        .o_ID_EX_rd(s_rd), .o_ctrl(s_ctrl), .o_data_a(s_a),
        .o_data_b(s_b), .o_imm(s_imm), .o_valid(s_valid), .o_bubble_cnt(s_cnt)
    );

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [9:0] c, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d,
                            input logic ur, input logic [31:0] a);
        ctrl = c; rs = s; rt = t; rd = d; uses_rt = ur;
        da = a; db = a + 32'h100; imm = a + 32'h200;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; cnt_clear = 1'b0;
        drive_id(10'h000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        #3;
        checks++;
        if ({valid, ex_ctrl, cnt, stall} !== 28'h0) begin
            errors++; $display("FAIL reset_init: valid/ctrl/cnt/stall=%h want 0", {valid, ex_ctrl, cnt, stall});
        end
        @(negedge clk); rst_n = 1'b1;
        drive_id(10'h3FF, 5'd6, 5'd7, 5'd8, 1'b1, 32'hDEAD);
        step();
        checks++;
        if (valid !== 1'b1 || ex_ctrl !== 10'h3FF) begin
            errors++; $display("FAIL reset_preload: valid=%b ctrl=%h want 1/3ff", valid, ex_ctrl);
        end
        #2; rst_n = 1'b0; #1;
        checks++;
        if ({valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, cnt, stall} !== '0) begin
            errors++; $display("FAIL reset_async: valid=%b ctrl=%h rs=%0d a=%h want all 0", valid, ex_ctrl, ex_rs, ex_a);
        end
        #1; rst_n = 1'b1;
        drive_id(10'h000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_pass_through();
        drive_id(10'h021, 5'd1, 5'd2, 5'd3, 1'b1, 32'hA);
        step();
        checks++;
        if (ex_ctrl !== 10'h021 || ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_rd !== 5'd3) begin
            errors++; $display("FAIL pass_fields: ctrl=%h rs=%0d rt=%0d rd=%0d want 021/1/2/3", ex_ctrl, ex_rs, ex_rt, ex_rd);
        end
        checks++;
        if (ex_a !== 32'hA || ex_b !== 32'h10A || ex_imm !== 32'h20A) begin
            errors++; $display("FAIL pass_data: a=%h b=%h imm=%h want a/10a/20a", ex_a, ex_b, ex_imm);
        end
        checks++;
        if (valid !== 1'b1 || stall !== 1'b0 || cnt !== 16'd0) begin
            errors++; $display("FAIL pass_status: valid=%b stall=%b cnt=%0d want 1/0/0", valid, stall, cnt);
        end
    endtask

    task automatic test_load_use();
        drive_id(10'h00B, 5'd0, 5'd5, 5'd0, 1'b0, 32'h1);
        step();
        drive_id(10'h021, 5'd5, 5'd1, 5'd2, 1'b0, 32'h55);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: stall=%b want 1", stall);
        end
        step();
        checks++;
        if (ex_ctrl !== 10'h0 || valid !== 1'b0 || cnt !== 16'd1 || stall !== 1'b0 || ex_rs !== 5'd0) begin
            errors++; $display("FAIL lu_bubble: ctrl=%h valid=%b cnt=%0d stall=%b rs=%0d want 0/0/1/0/0", ex_ctrl, valid, cnt, stall, ex_rs);
        end
        step();
        checks++;
        if (valid !== 1'b1 || ex_rs !== 5'd5 || ex_a !== 32'h55 || cnt !== 16'd1) begin
            errors++; $display("FAIL lu_reload: valid=%b rs=%0d a=%h cnt=%0d want 1/5/55/1", valid, ex_rs, ex_a, cnt);
        end
    endtask

    task automatic test_no_false_stall();
        drive_id(10'h00B, 5'd0, 5'd0, 5'd0, 1'b0, 32'h2);
        step();
        drive_id(10'h021, 5'd0, 5'd0, 5'd4, 1'b1, 32'h3);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL nfs_r0: stall=%b want 0", stall);
        end
        drive_id(10'h00B, 5'd1, 5'd7, 5'd0, 1'b0, 32'h4);
        step();
        drive_id(10'h021, 5'd2, 5'd7, 5'd4, 1'b0, 32'h5);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL nfs_rt_unused: stall=%b want 0", stall);
        end
        uses_rt = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL nfs_rt_used: stall=%b want 1", stall);
        end
        uses_rt = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || ex_rs !== 5'd2 || cnt !== 16'd1) begin
            errors++; $display("FAIL nfs_load: valid=%b rs=%0d cnt=%0d want 1/2/1", valid, ex_rs, cnt);
        end
    endtask

    task automatic test_flush_stall_freeze();
        drive_id(10'h00B, 5'd0, 5'd9, 5'd0, 1'b0, 32'h6);
        step();
        drive_id(10'h021, 5'd9, 5'd1, 5'd3, 1'b0, 32'h7);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL fs_stall: stall=%b want 1", stall);
        end
        step();
        checks++;
        if (valid !== 1'b0 || ex_ctrl !== 10'h0 || cnt !== 16'd2) begin
            errors++; $display("FAIL fs_bubble: valid=%b ctrl=%h cnt=%0d want 0/0/2", valid, ex_ctrl, cnt);
        end
        // Frozen: flush and clear must both be ignored.
        enable = 1'b0; flush = 1'b1; cnt_clear = 1'b1;
        drive_id(10'h021, 5'd4, 5'd1, 5'd3, 1'b0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || ex_ctrl !== 10'h0 || cnt !== 16'd2 || ex_rs !== 5'd0) begin
                errors++; $display("FAIL freeze_%0d: valid=%b ctrl=%h cnt=%0d rs=%0d want 0/0/2/0", i, valid, ex_ctrl, cnt, ex_rs);
            end
        end
        enable = 1'b1; flush = 1'b0; cnt_clear = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || ex_rs !== 5'd4 || cnt !== 16'd2) begin
            errors++; $display("FAIL unfreeze: valid=%b rs=%0d cnt=%0d want 1/4/2", valid, ex_rs, cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        flush = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_s = (2 + k >= 3) ? 2'd3 : 2'(2 + k);
            checks++;
            if (s_cnt !== exp_s || cnt !== 16'(2 + k) || s_valid !== 1'b0) begin
                errors++; $display("FAIL sat_%0d: s_cnt=%0d cnt=%0d s_valid=%b want %0d/%0d/0", k, s_cnt, cnt, s_valid, exp_s, 2 + k);
            end
        end
        cnt_clear = 1'b1;
        step();
        checks++;
        if (s_cnt !== 2'd0 || cnt !== 16'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL clear_over_inc: s_cnt=%0d cnt=%0d valid=%b want 0/0/0", s_cnt, cnt, valid);
        end
        cnt_clear = 1'b0;
        step();
        checks++;
        if (s_cnt !== 2'd1 || cnt !== 16'd1) begin
            errors++; $display("FAIL post_clear: s_cnt=%0d cnt=%0d want 1/1", s_cnt, cnt);
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_stall_freeze();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
